// File: rtl/aes_pkg.sv
// Shared AES key-schedule types and helpers: word type, engine state encoding,
// round/word-count derivation and GF(2^8) doubling.
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int calc_nr(input int nk);
        return nk + 6;
    endfunction

    function automatic int calc_nw(input int nr);
        return 4 * (nr + 1);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry 0 sits in the most significant byte of the table.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] sel;

    assign sel      = 11'd2047 - {in_byte, 3'b000};
    assign out_byte = SBOX_TBL[sel -: 8];

endmodule

// File: rtl/key_expand_engine.sv
// AES key expansion engine streaming w[0..NW-1] over a valid/ready port.
// Optional round-key store enabled by defining KEY_EXPAND_ROUNDKEY_STORE_EN.
module key_expand_engine
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [NK*32-1:0] key_in,
    output logic             word_valid,
    input  logic             word_ready,
    output word_t            word_data,
    output logic [5:0]       word_idx,
    output logic             word_last,
    output logic             busy,
    input  logic [5:0]       rd_idx,
    output word_t            rd_data
);

    localparam int         NR       = calc_nr(NK);
    localparam int         NW       = calc_nw(NR);
    localparam logic [5:0] LAST_IDX = 6'(NW - 1);
    localparam logic [2:0] PH_MAX   = 3'(NK - 1);

    state_t     state, state_nxt;
    word_t      win [NK];
    logic [5:0] idx;
    logic [2:0] phase;
    logic [7:0] rcon;
    logic       start_fire, xfer;
    word_t      tail, rot, sub_in, sub_out, t, new_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        word_valid  = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                word_valid = 1'b1;
                busy       = 1'b1;
                if (word_ready && (idx == LAST_IDX)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign start_fire = start_valid && start_ready;
    assign xfer       = word_valid && word_ready;
    assign word_idx   = idx;
    assign word_last  = word_valid && (idx == LAST_IDX);
    assign word_data  = word_valid ? win[0] : '0;

    // phase tracks idx % NK without a divider; rcon is consumed whenever a
    // word with index % NK == 0 is produced into the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            phase <= '0;
            rcon  <= 8'h01;
        end else if (start_fire) begin
            idx   <= '0;
            phase <= '0;
            rcon  <= 8'h01;
        end else if (xfer) begin
            idx   <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
            phase <= (phase == PH_MAX) ? 3'd0 : phase + 3'd1;
            if (phase == 3'd0) begin
                rcon <= xtime(rcon);
            end
        end
    end

    // win[k] holds w[idx+k]; each transfer shifts in w[idx+NK], which needs
    // only w[idx] (oldest) and w[idx+NK-1] (newest), so NK words of history.
    always_ff @(posedge clk) begin
        if (start_fire) begin
            for (int k = 0; k < NK; k++) begin
                win[k] <= key_in[NK*32-1-32*k -: 32];
            end
        end else if (xfer) begin
            for (int k = 0; k < NK - 1; k++) begin
                win[k] <= win[k+1];
            end
            win[NK-1] <= new_word;
        end
    end

    assign tail   = win[NK-1];
    assign rot    = {tail[23:0], tail[31:24]};
    assign sub_in = (phase == 3'd0) ? rot : tail;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (sub_in[8*b +: 8]),
            .out_byte (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        t = tail;
        if (phase == 3'd0) begin
            t = sub_out ^ {rcon, 24'h000000};
        end else if ((NK == 8) && (phase == 3'd4)) begin
            t = sub_out;
        end
        new_word = win[0] ^ t;
    end

`ifdef KEY_EXPAND_ROUNDKEY_STORE_EN
    word_t store [NW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NW; k++) begin
                store[k] <= '0;
            end
        end else if (start_fire) begin
            for (int k = 0; k < NW; k++) begin
                store[k] <= '0;
            end
        end else if (xfer) begin
            store[idx] <= win[0];
        end
    end

    assign rd_data = (rd_idx < 6'(NW)) ? store[rd_idx] : '0;
`else
    logic unused_rd_idx;

    assign unused_rd_idx = ^rd_idx;
    assign rd_data       = '0;
`endif

endmodule

// File: tb/tb_key_expand_engine.sv
// Scoreboard bench for key_expand_engine at NK=4/6/8 against a bench-side
// key-schedule model with an algorithmically derived S-box.
module tb_key_expand_engine;

    localparam logic [255:0] K4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] key_bus;
    logic         word_ready;
    logic [5:0]   rd_idx;
    logic         start_v;
    int           sel;

    logic        sv4, sv6, sv8, sr4, sr6, sr8, wv4, wv6, wv8;
    logic        wl4, wl6, wl8, bz4, bz6, bz8;
    logic [31:0] wd4, wd6, wd8, rd4, rd6, rd8;
    logic [5:0]  wi4, wi6, wi8;

    logic        cur_valid, cur_last, cur_busy, cur_start_ready;
    logic [31:0] cur_data, cur_rd;
    logic [5:0]  cur_idx;

    typedef struct {
        logic [31:0] w;
        int          idx;
        logic        last;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  tsb [256];
    logic [31:0] model_w [64];
    logic [31:0] obs_w [64];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign sv4 = start_v && (sel == 4);
    assign sv6 = start_v && (sel == 6);
    assign sv8 = start_v && (sel == 8);

    key_expand_engine #(.NK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4),
        .key_in(key_bus[255:128]), .word_valid(wv4), .word_ready(word_ready),
        .word_data(wd4), .word_idx(wi4), .word_last(wl4), .busy(bz4),
        .rd_idx(rd_idx), .rd_data(rd4)
    );

    key_expand_engine #(.NK(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv6), .start_ready(sr6),
        .key_in(key_bus[255:64]), .word_valid(wv6), .word_ready(word_ready),
        .word_data(wd6), .word_idx(wi6), .word_last(wl6), .busy(bz6),
        .rd_idx(rd_idx), .rd_data(rd6)
    );

    key_expand_engine #(.NK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
        .key_in(key_bus), .word_valid(wv8), .word_ready(word_ready),
        .word_data(wd8), .word_idx(wi8), .word_last(wl8), .busy(bz8),
        .rd_idx(rd_idx), .rd_data(rd8)
    );

    always_comb begin
        cur_valid = wv4; cur_data = wd4; cur_idx = wi4; cur_last = wl4;
        cur_busy = bz4; cur_start_ready = sr4; cur_rd = rd4;
        case (sel)
            6: begin
                cur_valid = wv6; cur_data = wd6; cur_idx = wi6; cur_last = wl6;
                cur_busy = bz6; cur_start_ready = sr6; cur_rd = rd6;
            end
            8: begin
                cur_valid = wv8; cur_data = wd8; cur_idx = wi8; cur_last = wl8;
                cur_busy = bz8; cur_start_ready = sr8; cur_rd = rd8;
            end
            default: ;
        endcase
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, y;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int j = 1; j < 256; j++) begin
                y = 8'(j);
                if (gmul(8'(x), y) == 8'h01) inv = y;
            end
            tsb[x] = inv ^ rl8(inv, 1) ^ rl8(inv, 2) ^ rl8(inv, 3) ^ rl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {tsb[v[31:24]], tsb[v[23:16]], tsb[v[15:8]], tsb[v[7:0]]};
    endfunction

    task automatic model_expand(input logic [255:0] key, input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        int          nw;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        for (int i = 0; i < nk; i++) model_w[i] = key[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = model_w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            model_w[i] = model_w[i-nk] ^ t;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the first output cycle.
    task automatic do_start(input int nk, input logic [255:0] key);
        int nw;
        exp_t e;
        nw = 4 * (nk + 7);
        sel = nk;
        model_expand(key, nk);
        for (int i = 0; i < nw; i++) begin
            e.w = model_w[i]; e.idx = i; e.last = (i == nw - 1);
            sbq.push_back(e);
        end
        for (int i = 0; i < 64; i++) obs_w[i] = 32'h0;
        key_bus = key;
        start_v = 1'b1;
        #0;
        n_checks++;
        if (cur_start_ready !== 1'b1 || cur_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_before_start nk=%0d: start_ready=%b busy=%b, required 1 0", nk, cur_start_ready, cur_busy);
        end
        @(posedge clk); #1;
        start_v = 1'b0;
        n_checks++;
        if (cur_valid !== 1'b1 || cur_start_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL start_latency nk=%0d: word_valid=%b start_ready=%b, required 1 0", nk, cur_valid, cur_start_ready);
        end
    endtask

    task automatic drain(input bit stall, input int stop_at, input int pulse_at,
                         output int xfers, output int cycles);
        int budget;
        bit pulsed;
        budget = 400; pulsed = 0; xfers = 0; cycles = 0;
        while (sbq.size() > 0) begin
            if (budget == 0) begin
                n_checks++; n_fail++;
                $display("FAIL drain_timeout: %0d words outstanding, required 0", sbq.size());
                sbq.delete();
                break;
            end
            budget--;
            start_v = 1'b0;
            word_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            n_checks++;
            if (cur_valid !== 1'b1 || cur_busy !== 1'b1 || cur_start_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL run_flags: valid=%b busy=%b start_ready=%b, required 1 1 0", cur_valid, cur_busy, cur_start_ready);
            end
            n_checks++;
            if (cur_idx !== 6'(sbq[0].idx)) begin
                n_fail++;
                $display("FAIL word_idx: got %0d, required %0d", cur_idx, sbq[0].idx);
            end
            n_checks++;
            if (cur_data !== sbq[0].w) begin
                n_fail++;
                $display("FAIL word_data idx=%0d: got %h, required %h", sbq[0].idx, cur_data, sbq[0].w);
            end
            n_checks++;
            if (cur_last !== sbq[0].last) begin
                n_fail++;
                $display("FAIL word_last idx=%0d: got %b, required %b", sbq[0].idx, cur_last, sbq[0].last);
            end
            if (stop_at >= 0 && sbq[0].idx == stop_at) begin
                word_ready = 1'b0;
                break;
            end
            if (pulse_at >= 0 && !pulsed && sbq[0].idx == pulse_at) begin
                start_v = 1'b1;
                key_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                pulsed = 1;
            end
            if (word_ready) begin
                obs_w[sbq[0].idx] = cur_data;
                void'(sbq.pop_front());
                xfers++;
            end
            cycles++;
            @(posedge clk); #1;
        end
        start_v = 1'b0;
        if (stop_at < 0) begin
            n_checks++;
            if (cur_valid !== 1'b0 || cur_start_ready !== 1'b1 || cur_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL return_idle: valid=%b start_ready=%b busy=%b, required 0 1 0", cur_valid, cur_start_ready, cur_busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_v = 1'b0; word_ready = 1'b0; rd_idx = 6'd0;
        key_bus = '0; sel = 4;
        repeat (3) @(posedge clk);
        for (int s = 4; s <= 8; s += 2) begin
            sel = s;
            #1;
            n_checks++;
            if (cur_valid !== 1'b0 || cur_data !== 32'h0 || cur_idx !== 6'd0 ||
                cur_last !== 1'b0 || cur_busy !== 1'b0 || cur_rd !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs nk=%0d: valid=%b data=%h idx=%0d last=%b busy=%b rd=%h, required all 0",
                         s, cur_valid, cur_data, cur_idx, cur_last, cur_busy, cur_rd);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (sr4 !== 1'b1 || sr6 !== 1'b1 || sr8 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_start_ready: got %b%b%b, required 111", sr4, sr6, sr8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_nk4();
        int x, c;
        do_start(4, K4);
        drain(1'b0, -1, -1, x, c);
        n_checks++;
        if (x != 44 || c != 44) begin
            n_fail++;
            $display("FAIL nk4_throughput: %0d transfers in %0d cycles, required 44 in 44", x, c);
        end
        n_checks++;
        if (obs_w[4] !== 32'ha0fafe17 || obs_w[43] !== 32'hb6630ca6) begin
            n_fail++;
            $display("FAIL nk4_vectors: w4=%h w43=%h, required a0fafe17 b6630ca6", obs_w[4], obs_w[43]);
        end
    endtask

    task automatic test_nk6();
        int x, c;
        do_start(6, K6);
        drain(1'b0, -1, -1, x, c);
        n_checks++;
        if (obs_w[6] !== 32'hfe0c91f7 || obs_w[51] !== 32'h01002202 || x != 52) begin
            n_fail++;
            $display("FAIL nk6_vectors: w6=%h w51=%h xfers=%0d, required fe0c91f7 01002202 52", obs_w[6], obs_w[51], x);
        end
    endtask

    task automatic test_nk8();
        int x, c;
        do_start(8, K8);
        drain(1'b0, -1, -1, x, c);
        n_checks++;
        if (obs_w[8] !== 32'h9ba35411 || obs_w[12] !== 32'ha8b09c1a || obs_w[59] !== 32'h706c631e || x != 60) begin
            n_fail++;
            $display("FAIL nk8_vectors: w8=%h w12=%h w59=%h xfers=%0d, required 9ba35411 a8b09c1a 706c631e 60",
                     obs_w[8], obs_w[12], obs_w[59], x);
        end
    endtask

    task automatic test_stalls();
        int x, c;
        do_start(4, K4);
        drain(1'b1, -1, -1, x, c);
        n_checks++;
        if (x != 44 || obs_w[43] !== 32'hb6630ca6) begin
            n_fail++;
            $display("FAIL stall_sequence: xfers=%0d w43=%h, required 44 b6630ca6", x, obs_w[43]);
        end
    endtask

    task automatic test_back_to_back();
        int x, c;
        do_start(4, K4);
        drain(1'b0, -1, -1, x, c);
        do_start(4, {$urandom, $urandom, $urandom, $urandom, 128'h0});
        drain(1'b1, -1, -1, x, c);
        n_checks++;
        if (x != 44) begin
            n_fail++;
            $display("FAIL back_to_back_count: %0d transfers, required 44", x);
        end
    endtask

    task automatic test_reset_mid();
        int x, c;
        do_start(4, K4);
        drain(1'b0, 20, -1, x, c);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (cur_valid !== 1'b0 || cur_data !== 32'h0 || cur_idx !== 6'd0 ||
            cur_last !== 1'b0 || cur_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: valid=%b data=%h idx=%0d last=%b busy=%b, required all 0",
                     cur_valid, cur_data, cur_idx, cur_last, cur_busy);
        end
        sbq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (cur_start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_reset_ready: start_ready=%b, required 1", cur_start_ready);
        end
        @(posedge clk); #1;
        do_start(4, K4);
        drain(1'b0, -1, -1, x, c);
        n_checks++;
        if (obs_w[0] !== 32'h2b7e1516 || obs_w[4] !== 32'ha0fafe17 || x != 44) begin
            n_fail++;
            $display("FAIL restart_sequence: w0=%h w4=%h xfers=%0d, required 2b7e1516 a0fafe17 44", obs_w[0], obs_w[4], x);
        end
    endtask

    task automatic test_start_ignored();
        int x, c;
        do_start(4, K4);
        drain(1'b0, -1, 10, x, c);
        n_checks++;
        if (x != 44 || obs_w[43] !== 32'hb6630ca6) begin
            n_fail++;
            $display("FAIL start_in_run: xfers=%0d w43=%h, required 44 b6630ca6", x, obs_w[43]);
        end
    endtask

    task automatic test_store();
        int x, c;
        sel = 4;
`ifdef KEY_EXPAND_ROUNDKEY_STORE_EN
        rd_idx = 6'd43; #1;
        n_checks++;
        if (cur_rd !== 32'hb6630ca6) begin
            n_fail++;
            $display("FAIL store_rd43: got %h, required b6630ca6", cur_rd);
        end
        rd_idx = 6'd0; #1;
        n_checks++;
        if (cur_rd !== 32'h2b7e1516) begin
            n_fail++;
            $display("FAIL store_rd0: got %h, required 2b7e1516", cur_rd);
        end
        rd_idx = 6'd50; #1;
        n_checks++;
        if (cur_rd !== 32'h0) begin
            n_fail++;
            $display("FAIL store_rd50: got %h, required 0", cur_rd);
        end
        @(posedge clk); #1;
        do_start(4, K4);
        rd_idx = 6'd43;
        #0;
        n_checks++;
        if (cur_rd !== 32'h0) begin
            n_fail++;
            $display("FAIL store_clear_on_start: got %h, required 0", cur_rd);
        end
        drain(1'b0, -1, -1, x, c);
`else
        for (int r = 0; r < 64; r += 21) begin
            rd_idx = 6'(r); #1;
            n_checks++;
            if (rd4 !== 32'h0 || rd6 !== 32'h0 || rd8 !== 32'h0) begin
                n_fail++;
                $display("FAIL rd_data_zero rd_idx=%0d: got %h %h %h, required 0", r, rd4, rd6, rd8);
            end
        end
        x = 0; c = 0;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        test_reset();
        test_nk4();
        test_nk6();
        test_nk8();
        test_stalls();
        test_back_to_back();
        test_reset_mid();
        test_start_ignored();
        test_store();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_expand_engine.md
KEY_EXPAND_ENGINE -- requirements
Module: key_expand_engine

Interface
REQ-001 Parameter NK, default 4, meaning key length in 32-bit words; legal values 4, 6 and 8 (AES-128/192/256).
REQ-002 Derived constant NR = NK+6 and NW = 4*(NR+1), giving 44, 52 or 60 words.
REQ-003 The ports SHALL be, in order:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  request to expand key_in.
- start_ready  output  1  engine can accept a request.
- key_in  input  NK*32  cipher key; w[0] = key_in[NK*32-1 -: 32], w[NK-1] = key_in[31:0].
- word_valid  output  1  word_data is valid.
- word_ready  input  1  consumer accepts the word.
- word_data  output  32  expanded word w[word_idx].
- word_idx  output  6  index of the current word.
- word_last  output  1  current word is w[NW-1].
- busy  output  1  expansion in progress.
- rd_idx  input  6  stored-word read index.
- rd_data  output  32  stored word (see Configuration).

Function
REQ-004 The state machine SHALL have two states: IDLE and RUN.
REQ-005 In IDLE, start_ready SHALL be 1; the start handshake (start_valid && start_ready) SHALL latch key_in, set word_idx to 0, load rcon to 0x01 and enter RUN.
REQ-006 In RUN, word_valid and busy SHALL be 1 and start_ready SHALL be 0; start_valid SHALL be ignored.
REQ-007 word_valid SHALL first rise the cycle after the start handshake (latency 1).
REQ-008 A transfer SHALL occur when word_valid && word_ready, and each transfer SHALL advance word_idx by 1.
REQ-009 word_data, word_idx and word_last SHALL hold stable while word_valid=1 and word_ready=0.
REQ-010 For i < NK, w[i] SHALL equal key word i.
REQ-011 For i >= NK, the rule SHALL be: t = w[i-1].
- If i%NK==0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}.
- Else if NK==8 and i%NK==4: t = SubWord(t).
- Then w[i] = w[i-NK] ^ t.
REQ-012 RotWord(t) SHALL equal {t[23:0], t[31:24]}.
REQ-013 SubWord SHALL apply the AES S-box to each byte independently.
REQ-014 rcon SHALL advance by GF(2^8) doubling (xtime, reduction 0x1B) after each transfer with i%NK==0 and i>=NK, giving the sequence 01,02,04,08,10,20,40,80,1B,36.
REQ-015 The transfer of w[NW-1] (word_last=1) SHALL return the engine to IDLE on the next edge; a new start SHALL be acceptable in that IDLE cycle.
REQ-016 The engine SHALL need no more than NK words of history; a full NW-word store SHALL exist only under the Configuration macro.

Reset
REQ-017 Asserting rst_n=0 at any time SHALL immediately force IDLE, including mid-expansion with no completion.
REQ-018 During reset: word_valid=0, word_data=0, word_idx=0, word_last=0, busy=0, rcon=0x01 and start_ready=1 once rst_n is released.

Configuration
REQ-019 Macro KEY_EXPAND_ROUNDKEY_STORE_EN defined: every transferred word SHALL be written to an NW x 32 store at word_idx.
- rd_data = store[rd_idx], combinational.
- rd_idx >= NW SHALL return 0.
- The store SHALL clear on reset and on each start handshake.
REQ-020 Macro undefined: no store SHALL be built, rd_data SHALL be constant 0 and rd_idx SHALL be unused.

Structure
REQ-021 Shared package aes_pkg SHALL hold the 32-bit word typedef, the state enum, the NR/NW derivation functions and the xtime function.
REQ-022 Sub-module aes_sbox SHALL be a combinational 8-bit S-box, instantiated four times for SubWord.

Verification
REQ-023 NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, word_ready=1 -> w[4]=a0fafe17, w[43]=b6630ca6, word_last only at idx 43, 44 transfers in 44 consecutive cycles.
REQ-024 NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> w[6]=fe0c91f7, w[51]=01002202.
REQ-025 NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> w[8]=9ba35411, w[12]=a8b09c1a, w[59]=706c631e.
REQ-026 Random word_ready stalls (NK=4) -> identical 44-word sequence, outputs stable during stalls, no loss or duplication.
REQ-027 Reset asserted at idx 20, then released, then a new start -> immediate IDLE with zeroed outputs, restart from idx 0 with rcon 01.
REQ-028 start_valid pulsed in RUN -> ignored, and the current sequence is unaffected.
REQ-029 With the macro: after completion, rd_idx=43 -> b6630ca6 and rd_idx=50 -> 0; without the macro, rd_data is always 0.
